wb_interconnect_nxm: RTL and testbench

Parametrised shared-bus Wishbone classic interconnect. Connects NUM_MASTERS masters to NUM_SLAVES slaves through a round-robin arbiter and a slave-select decoder on the top address bits. Adds a bus-timeout watchdog that terminates unanswered cycles with err. Successor to the fixed 2x2 interconnect between the UART bridge, the levenshtein controller and the SPI SRAM controller.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_rr_arbiter.sv | 25 ++
 rtl/wb_interconnect_nxm.sv | 119 +++++++++++
 tb/tb_wb_interconnect_nxm.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM type and width helpers for the Wishbone interconnect
package wb_pkg;
    typedef enum logic {IDLE, BUSY} state_e;
    function automatic int sel_bits(input int n);
        return $clog2(n);
    endfunction
    function automatic int saddr_width(input int aw, input int n);
        return aw - $clog2(n);
    endfunction
    function automatic int idx_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: picks the first requester after the round-robin pointer, wrapping
module wb_rr_arbiter import wb_pkg::*; #(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);
    logic [IW-1:0] j;
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        j = '0;
        // descending scan so the closest requester after the pointer wins last
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (req_i[j]) begin
                idx_o = j;
                vld_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_interconnect_nxm.sv
// wb_interconnect_nxm: round-robin shared-bus Wishbone classic interconnect with bus-timeout watchdog
module wb_interconnect_nxm import wb_pkg::*; #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 2,
    parameter int ADDR_WIDTH  = 23,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT     = 255,
    parameter int SEL_BITS    = sel_bits(NUM_SLAVES),
    parameter int SADDR_WIDTH = saddr_width(ADDR_WIDTH, NUM_SLAVES),
    parameter int SEL_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]            wbm_stb_i,
    input  logic [NUM_MASTERS-1:0]            wbm_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] wbm_adr_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  wbm_sel_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] wbm_dat_i,
    output logic [NUM_MASTERS-1:0]            wbm_ack_o,
    output logic [NUM_MASTERS-1:0]            wbm_err_o,
    output logic [NUM_MASTERS-1:0]            wbm_rty_o,
    output logic [DATA_WIDTH-1:0]             wbm_dat_o,
    output logic [NUM_SLAVES-1:0]             wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]             wbs_stb_o,
    output logic                              wbs_we_o,
    output logic [SADDR_WIDTH-1:0]            wbs_adr_o,
    output logic [SEL_WIDTH-1:0]              wbs_sel_o,
    output logic [DATA_WIDTH-1:0]             wbs_dat_o,
    input  logic [NUM_SLAVES-1:0]             wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]             wbs_err_i,
    input  logic [NUM_SLAVES-1:0]             wbs_rty_i,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  wbs_dat_i
);
    localparam int IW = idx_width(NUM_MASTERS);
    localparam int CW = $clog2(TIMEOUT + 1) + 1;
    state_e st_q, st_d;
    logic [IW-1:0] gnt_q, gnt_d, ptr_q, ptr_d, arb_idx;
    logic arb_vld;
    logic [CW-1:0] cnt_q, cnt_d;
    logic to_q, to_d;
    logic busy, m_cyc, m_stb, live, s_term, count, hit;
    logic [ADDR_WIDTH-1:0] adr;
    logic [SEL_BITS-1:0] slv;

    wb_rr_arbiter #(.N(NUM_MASTERS), .IW(IW)) u_arb (
        .req_i(wbm_cyc_i),
        .ptr_i(ptr_q),
        .idx_o(arb_idx),
        .vld_o(arb_vld)
    );

    assign busy   = st_q == BUSY;
    assign adr    = wbm_adr_i[gnt_q*ADDR_WIDTH +: ADDR_WIDTH];
    assign slv    = adr[ADDR_WIDTH-1 -: SEL_BITS];
    assign m_cyc  = busy & wbm_cyc_i[gnt_q];
    assign m_stb  = m_cyc & wbm_stb_i[gnt_q];
    // once timed out the slave is cut off until the owner drops cyc
    assign live   = m_stb & ~to_q;
    assign s_term = wbs_ack_i[slv] | wbs_err_i[slv] | wbs_rty_i[slv];
    assign count  = (TIMEOUT != 0) & live & ~s_term;
    assign hit    = count & (cnt_q == CW'(TIMEOUT - 1));

    assign wbs_we_o  = wbm_we_i[gnt_q];
    assign wbs_adr_o = adr[SADDR_WIDTH-1:0];
    assign wbs_sel_o = wbm_sel_i[gnt_q*SEL_WIDTH +: SEL_WIDTH];
    assign wbs_dat_o = wbm_dat_i[gnt_q*DATA_WIDTH +: DATA_WIDTH];
    assign wbm_dat_o = busy ? wbs_dat_i[slv*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_comb begin
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        wbs_cyc_o[slv] = m_cyc & ~to_q;
        wbs_stb_o[slv] = live;
        wbm_ack_o[gnt_q] = live & wbs_ack_i[slv];
        wbm_err_o[gnt_q] = (live & wbs_err_i[slv]) | hit;
        wbm_rty_o[gnt_q] = live & wbs_rty_i[slv];
    end

    always_comb begin
        st_d = st_q;
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        to_d = to_q;
        cnt_d = count ? cnt_q + CW'(1) : '0;
        if (!busy) begin
            to_d = 1'b0;
            if (arb_vld) begin
                st_d = BUSY;
                gnt_d = arb_idx;
                ptr_d = arb_idx;
            end
        end else if (!wbm_cyc_i[gnt_q]) begin
            st_d = IDLE;
            to_d = 1'b0;
        end else if (hit) begin
            to_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q <= IDLE;
            gnt_q <= '0;
            ptr_q <= IW'(NUM_MASTERS - 1);
            cnt_q <= '0;
            to_q <= 1'b0;
        end else begin
            st_q <= st_d;
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            to_q <= to_d;
        end
    end
endmodule

// File: tb/tb_wb_interconnect_nxm.sv
// tb_wb_interconnect_nxm: directed scenarios plus randomized run against a behavioural model
module tb_wb_interconnect_nxm;
    localparam int NM = 2, NS = 2, AW = 23, DW = 8, TO = 4, SAW = 22, SW = 1;
    logic clk = 1'b0, rst = 1'b0;
    logic [NM-1:0] m_cyc, m_stb, m_we, m_ack, m_err, m_rty;
    logic [NM*AW-1:0] m_adr;
    logic [NM*SW-1:0] m_sel;
    logic [NM*DW-1:0] m_dat;
    logic [DW-1:0] m_rdat;
    logic [NS-1:0] s_cyc, s_stb, s_ack, s_err, s_rty;
    logic s_we;
    logic [SAW-1:0] s_adr;
    logic [SW-1:0] s_sel;
    logic [DW-1:0] s_wdat;
    logic [NS*DW-1:0] s_rdat;
    int n_chk = 0, n_fail = 0;
    int owner = -1, last = NM - 1, waited = 0;
    bit dead = 1'b0;
    logic [NM-1:0] e_ack, e_err, e_rty;
    logic [NS-1:0] e_cyc, e_stb;
    logic [DW-1:0] e_dat;

    wb_interconnect_nxm #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_we_i(m_we), .wbm_adr_i(m_adr),
        .wbm_sel_i(m_sel), .wbm_dat_i(m_dat),
        .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty), .wbm_dat_o(m_rdat),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_we_o(s_we), .wbs_adr_o(s_adr),
        .wbs_sel_o(s_sel), .wbs_dat_o(s_wdat),
        .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty), .wbs_dat_i(s_rdat)
    );

    always #5 clk = ~clk;

    // expected outputs for the current cycle: owner's target slave sees its cyc/stb unless cut off
    function automatic void model_eval();
        int s;
        bit gate;
        {e_ack, e_err, e_rty, e_cyc, e_stb, e_dat} = '0;
        if (owner < 0) return;
        s = int'(m_adr[owner*AW + AW - 1]);
        e_dat = s_rdat[s*DW +: DW];
        if (dead) return;
        e_cyc[s] = m_cyc[owner];
        e_stb[s] = m_stb[owner];
        gate = m_cyc[owner] & m_stb[owner];
        e_ack[owner] = gate & s_ack[s];
        e_rty[owner] = gate & s_rty[s];
        e_err[owner] = gate & (s_err[s] | (!(s_ack[s] | s_err[s] | s_rty[s]) && waited + 1 == TO));
    endfunction

    function automatic void model_clock();
        int s;
        bit found;
        if (rst) begin
            owner = -1; last = NM - 1; waited = 0; dead = 1'b0;
            return;
        end
        if (owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= NM; k++)
                if (!found && m_cyc[(last + k) % NM]) begin
                    owner = (last + k) % NM;
                    found = 1'b1;
                end
            if (found) last = owner;
            return;
        end
        if (!m_cyc[owner]) begin
            owner = -1; waited = 0; dead = 1'b0;
            return;
        end
        s = int'(m_adr[owner*AW + AW - 1]);
        if (m_stb[owner] && !dead && !(s_ack[s] | s_err[s] | s_rty[s])) begin
            waited++;
            if (waited == TO) begin dead = 1'b1; waited = 0; end
        end else waited = 0;
    endfunction

    task automatic adv();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {m_cyc, m_stb, m_we, m_adr, m_sel, m_dat} = '0;
        {s_ack, s_err, s_rty, s_rdat} = '0;
        adv();
        rst = 1'b0;
    endtask

    task automatic set_m(input int i, input bit cyc, input bit stb, input bit we, input logic [AW-1:0] adr);
        m_cyc[i] = cyc; m_stb[i] = stb; m_we[i] = we; m_adr[i*AW +: AW] = adr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_cyc = 2'b11; m_stb = 2'b11; s_ack = 2'b11; s_rdat = 16'h5AA5;
        adv();
        adv();
        #1;
        if ({s_cyc, s_stb} !== 4'b0) begin $display("FAIL reset_slave_cyc: got %b want 0000", {s_cyc, s_stb}); n_fail++; end
        n_chk++;
        if ({m_ack, m_err, m_rty} !== 6'b0) begin $display("FAIL reset_master_term: got %b want 000000", {m_ack, m_err, m_rty}); n_fail++; end
        n_chk++;
        if (m_rdat !== 8'h00) begin $display("FAIL reset_rdat: got %h want 00", m_rdat); n_fail++; end
        n_chk++;
        do_reset();
    endtask

    task automatic test_rotation();
        set_m(0, 1, 1, 0, 23'h000000);
        set_m(1, 1, 1, 1, 23'h000020);
        #1;
        if (s_cyc !== 2'b00) begin $display("FAIL rot_idle_cycle: got %b want 00", s_cyc); n_fail++; end
        n_chk++;
        adv();
        s_ack = 2'b01;
        #1;
        if ({s_cyc, s_we, m_ack} !== 5'b01_0_01) begin $display("FAIL rot_first_m0: got %b want 01001", {s_cyc, s_we, m_ack}); n_fail++; end
        n_chk++;
        adv();
        s_ack = 2'b00;
        set_m(0, 0, 0, 0, 23'h000000);
        adv();
        #1;
        if (s_cyc !== 2'b00) begin $display("FAIL rot_dead_cycle: got %b want 00", s_cyc); n_fail++; end
        n_chk++;
        adv();
        s_ack = 2'b01;
        #1;
        if ({s_cyc, s_we, m_ack} !== 5'b01_1_10) begin $display("FAIL rot_second_m1: got %b want 01110", {s_cyc, s_we, m_ack}); n_fail++; end
        n_chk++;
        adv();
        s_ack = 2'b00;
        set_m(1, 0, 0, 1, 23'h000020);
        adv();
        set_m(0, 1, 1, 0, 23'h000000);
        set_m(1, 1, 1, 1, 23'h000020);
        adv();
        #1;
        if ({s_cyc, s_we} !== 3'b01_0) begin $display("FAIL rot_third_m0: got %b want 010", {s_cyc, s_we}); n_fail++; end
        n_chk++;
        do_reset();
    endtask

    task automatic test_decode();
        set_m(1, 1, 1, 0, 23'h400010);
        s_rdat = {8'hA5, 8'h3C};
        adv();
        s_ack = 2'b11;
        s_err = 2'b01;
        #1;
        if (s_cyc !== 2'b10) begin $display("FAIL dec_cyc: got %b want 10", s_cyc); n_fail++; end
        n_chk++;
        if (s_adr !== 22'h000010) begin $display("FAIL dec_adr: got %h want 000010", s_adr); n_fail++; end
        n_chk++;
        if ({m_ack, m_err, m_rdat} !== {2'b10, 2'b00, 8'hA5}) begin $display("FAIL dec_term: got %b/%b/%h want 10/00/a5", m_ack, m_err, m_rdat); n_fail++; end
        n_chk++;
        do_reset();
    endtask

    task automatic test_back_to_back();
        set_m(0, 1, 0, 0, 23'h000000);
        set_m(1, 1, 1, 1, 23'h400000);
        adv();
        for (int p = 0; p < 3; p++) begin
            set_m(0, 1, 1, 0, (p % 2) ? 23'h400000 + 23'(p) : 23'(p));
            s_ack = (p % 2) ? 2'b10 : 2'b01;
            #1;
            if ({m_ack, s_cyc} !== {2'b01, (p % 2) ? 2'b10 : 2'b01}) begin
                $display("FAIL b2b_phase%0d: got %b want 01%b", p, {m_ack, s_cyc}, (p % 2) ? 2'b10 : 2'b01); n_fail++;
            end
            n_chk++;
            adv();
            s_ack = 2'b00;
            m_stb[0] = 1'b0;
            #1;
            if ({s_stb, s_we} !== 3'b00_0) begin $display("FAIL b2b_gap%0d: got %b want 000", p, {s_stb, s_we}); n_fail++; end
            n_chk++;
            adv();
        end
        m_cyc[0] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            #1;
            if (s_cyc !== 2'b00) begin $display("FAIL b2b_handover%0d: got %b want 00", d, s_cyc); n_fail++; end
            n_chk++;
            adv();
        end
        #1;
        if ({s_cyc, s_we} !== 3'b10_1) begin $display("FAIL b2b_m1_granted: got %b want 101", {s_cyc, s_we}); n_fail++; end
        n_chk++;
        do_reset();
    endtask

    task automatic test_timeout();
        set_m(0, 1, 1, 0, 23'h400000);
        adv();
        for (int t = 1; t <= TO; t++) begin
            #1;
            if ({s_cyc, m_err} !== {2'b10, (t == TO) ? 2'b01 : 2'b00}) begin
                $display("FAIL to_cycle%0d: got %b want 10%b", t, {s_cyc, m_err}, (t == TO) ? 2'b01 : 2'b00); n_fail++;
            end
            n_chk++;
            adv();
        end
        s_ack = 2'b10;
        #1;
        if ({s_cyc, s_stb, m_ack, m_err} !== 8'b0) begin $display("FAIL to_cut_off: got %b want 00000000", {s_cyc, s_stb, m_ack, m_err}); n_fail++; end
        n_chk++;
        adv();
        s_ack = 2'b00;
        m_cyc[0] = 1'b0;
        adv();
        m_cyc[0] = 1'b1;
        adv();
        #1;
        if (s_cyc !== 2'b10) begin $display("FAIL to_recovered: got %b want 10", s_cyc); n_fail++; end
        n_chk++;
        do_reset();
    endtask

    task automatic test_ack_at_timeout();
        set_m(0, 1, 1, 0, 23'h400000);
        adv();
        repeat (TO - 1) adv();
        s_ack = 2'b10;
        #1;
        if ({m_ack, m_err} !== 4'b01_00) begin $display("FAIL ack_wins: got %b want 0100", {m_ack, m_err}); n_fail++; end
        n_chk++;
        adv();
        s_ack = 2'b00;
        #1;
        if ({s_cyc, m_err} !== 4'b10_00) begin $display("FAIL ack_no_cutoff: got %b want 1000", {s_cyc, m_err}); n_fail++; end
        n_chk++;
        do_reset();
    endtask

    task automatic test_reset_mid();
        set_m(0, 1, 1, 0, 23'h000000);
        adv();
        rst = 1'b1;
        adv();
        rst = 1'b0;
        set_m(0, 0, 0, 0, 23'h000000);
        set_m(1, 1, 1, 1, 23'h000000);
        #1;
        if (s_cyc !== 2'b00) begin $display("FAIL rstmid_cyc_drop: got %b want 00", s_cyc); n_fail++; end
        n_chk++;
        adv();
        #1;
        if ({s_cyc, s_we} !== 3'b01_1) begin $display("FAIL rstmid_m1_granted: got %b want 011", {s_cyc, s_we}); n_fail++; end
        n_chk++;
        do_reset();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(0, 9) < 2) m_cyc[i] = ~m_cyc[i];
                m_stb[i] = m_cyc[i] & ($urandom_range(0, 3) != 0);
                m_we[i] = 1'($urandom);
                m_adr[i*AW +: AW] = AW'($urandom);
                m_sel[i*SW +: SW] = SW'($urandom);
                m_dat[i*DW +: DW] = DW'($urandom);
            end
            for (int j = 0; j < NS; j++) begin
                s_ack[j] = ($urandom_range(0, 5) == 0);
                s_err[j] = ($urandom_range(0, 11) == 0);
                s_rty[j] = ($urandom_range(0, 11) == 0);
            end
            s_rdat = (NS*DW)'($urandom);
            model_eval();
            #1;
            if ({m_ack, m_err, m_rty, s_cyc, s_stb, m_rdat} !== {e_ack, e_err, e_rty, e_cyc, e_stb, e_dat}) begin
                $display("FAIL rand_cycle%0d: got %b want %b", c, {m_ack, m_err, m_rty, s_cyc, s_stb, m_rdat}, {e_ack, e_err, e_rty, e_cyc, e_stb, e_dat});
                n_fail++;
            end
            n_chk++;
            if (owner >= 0) begin
                if ({s_we, s_adr, s_sel, s_wdat} !== {m_we[owner], m_adr[owner*AW +: SAW], m_sel[owner*SW +: SW], m_dat[owner*DW +: DW]}) begin
                    $display("FAIL rand_bus%0d: got %h want %h", c, {s_we, s_adr, s_sel, s_wdat}, {m_we[owner], m_adr[owner*AW +: SAW], m_sel[owner*SW +: SW], m_dat[owner*DW +: DW]});
                    n_fail++;
                end
                n_chk++;
            end
            adv();
        end
        rst = 1'b0;
        do_reset();
    endtask

    initial begin
        do_reset();
        test_reset();
        test_rotation();
        test_decode();
        test_back_to_back();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
